// File: rtl/hxmpp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hxmpp_pkg
// Purpose  : Shared constants and types for the hit-info queue slice.
// Revision : 1.0 - initial release
// ============================================================================
package hxmpp_pkg;

  localparam int HITINFOBITS        = 32;
  localparam int DEFAULT_DEPTH      = 16;
  localparam int DEFAULT_NLANES     = 4;
  localparam int DEFAULT_ALMOSTFULL = 12;
  localparam int DEFAULT_ERRCNTBITS = 16;

  typedef logic [HITINFOBITS-1:0] hit_info_t;

endpackage
`default_nettype wire

// File: rtl/lane_compactor.sv
`default_nettype none
// ============================================================================
// Module   : lane_compactor
// Purpose  : Prefix-counts the asserted push lanes in ascending order. It
//            assigns each lane its slot offset, accepts a lane only while its
//            rank is below the free space, and reports the accepted and
//            rejected totals.
// Revision : 1.0 - initial release
// ============================================================================
module lane_compactor
  import hxmpp_pkg::*;
#(
  parameter int  NLANES = DEFAULT_NLANES,
  parameter int  SPACEW = 5,
  localparam int NW     = $clog2(NLANES + 1)
) (
  input  logic [NLANES-1:0]    push,
  input  logic [SPACEW-1:0]    space,
  output logic [NLANES*NW-1:0] offset,
  output logic [NLANES-1:0]    accept,
  output logic [NW-1:0]        nAccepted,
  output logic [NW-1:0]        nRejected
);

  // rank of each asserted lane among the asserted lanes; a lane is accepted while rank < space
  always_comb begin
    logic [NW-1:0] rank;
    rank      = '0;
    offset    = '0;
    accept    = '0;
    nAccepted = '0;
    nRejected = '0;
    for (int i = 0; i < NLANES; i++) begin
      if (push[i]) begin
        offset[i*NW +: NW] = rank;
        if (32'(rank) < 32'(space)) begin
          accept[i] = 1'b1;
          nAccepted = nAccepted + NW'(1);
        end else begin
          nRejected = nRejected + NW'(1);
        end
        rank = rank + NW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/hit_info_queue_mc.sv
`default_nettype none
// ============================================================================
// Module   : hit_info_queue_mc
// Purpose  : Multi-lane circular hit-info queue with show-ahead head, per-event
//            flush, occupancy flags and saturating drop/underflow counters.
// Revision : 1.0 - initial release
// ============================================================================
module hit_info_queue_mc #(
  parameter int  HITINFOBITS = hxmpp_pkg::HITINFOBITS,
  parameter int  DEPTH       = hxmpp_pkg::DEFAULT_DEPTH,
  parameter int  NLANES      = hxmpp_pkg::DEFAULT_NLANES,
  parameter int  ALMOSTFULL  = hxmpp_pkg::DEFAULT_ALMOSTFULL,
  parameter int  ERRCNTBITS  = hxmpp_pkg::DEFAULT_ERRCNTBITS,
  localparam int CW          = $clog2(DEPTH + 1),
  localparam int NW          = $clog2(NLANES + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [NLANES-1:0]             push,
  input  logic [NLANES*HITINFOBITS-1:0] pushHitInfo,
  input  logic                          pop,
  output logic [HITINFOBITS-1:0]        headHitInfo,
  output logic                          headValid,
  output logic [CW-1:0]                 count,
  output logic                          full,
  output logic                          almost_full,
  output logic [ERRCNTBITS-1:0]         dropCount,
  output logic [ERRCNTBITS-1:0]         underflowCount
);

  localparam int            PW           = $clog2(DEPTH);
  localparam int unsigned   C_DEPTH_U    = DEPTH;
  localparam logic [CW-1:0] C_DEPTH      = CW'(DEPTH);
  localparam logic [CW-1:0] C_ALMOSTFULL = CW'(ALMOSTFULL);

  logic [HITINFOBITS-1:0] r_mem [DEPTH];
  logic [PW-1:0]          r_rdPtr;
  logic [PW-1:0]          r_wrPtr;
  logic [CW-1:0]          r_count;
  logic [ERRCNTBITS-1:0]  r_dropCount;
  logic [ERRCNTBITS-1:0]  r_underflowCount;

  logic                   w_empty;
  logic                   w_popEff;
  logic                   w_underflow;
  logic [CW-1:0]          w_space;
  logic [PW-1:0]          w_wrBase;
  logic [CW-1:0]          w_countBase;
  logic [NLANES*NW-1:0]   w_offset;
  logic [NLANES-1:0]      w_accept;
  logic [NW-1:0]          w_nAccepted;
  logic [NW-1:0]          w_nRejected;
  logic [PW-1:0]          w_wrAddr [NLANES];
  logic [ERRCNTBITS:0]    w_dropSum;

  // Pointer advance modulo DEPTH by compare-and-subtract; callers keep base+inc below 2*DEPTH.
  function automatic logic [PW-1:0] wrapAdd(input logic [PW-1:0] base, input int unsigned inc);
    int unsigned sum;
    sum = 32'(base) + inc;
    if (sum >= C_DEPTH_U) sum = sum - C_DEPTH_U;
    return PW'(sum);
  endfunction

  // Flush restarts the event from slot 0 with the whole buffer free and ignores any pop.
  assign w_empty     = (r_count == '0);
  assign w_popEff    = pop & ~flush & ~w_empty;
  assign w_underflow = pop & ~flush & w_empty;
  assign w_space     = flush ? C_DEPTH : (C_DEPTH - r_count + CW'(w_popEff));
  assign w_wrBase    = flush ? '0 : r_wrPtr;
  assign w_countBase = flush ? '0 : r_count;
  assign w_dropSum   = {1'b0, r_dropCount} + (ERRCNTBITS + 1)'(w_nRejected);

  lane_compactor #(
    .NLANES (NLANES),
    .SPACEW (CW)
  ) u_lane_compactor (
    .push      (push),
    .space     (w_space),
    .offset    (w_offset),
    .accept    (w_accept),
    .nAccepted (w_nAccepted),
    .nRejected (w_nRejected)
  );

  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    assign w_wrAddr[i] = wrapAdd(w_wrBase, 32'(w_offset[i*NW +: NW]));
  end

  // Accepted lanes land in distinct consecutive slots; storage is never cleared.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NLANES; i++) begin
        if (w_accept[i]) r_mem[w_wrAddr[i]] <= pushHitInfo[i*HITINFOBITS +: HITINFOBITS];
      end
    end
  end

  // Pointers, occupancy and saturating error counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdPtr          <= '0;
      r_wrPtr          <= '0;
      r_count          <= '0;
      r_dropCount      <= '0;
      r_underflowCount <= '0;
    end else begin
      r_wrPtr     <= wrapAdd(w_wrBase, 32'(w_nAccepted));
      r_rdPtr     <= flush ? '0 : wrapAdd(r_rdPtr, 32'(w_popEff));
      r_count     <= w_countBase + CW'(w_nAccepted) - CW'(w_popEff);
      r_dropCount <= w_dropSum[ERRCNTBITS] ? '1 : w_dropSum[ERRCNTBITS-1:0];
      if (w_underflow && (r_underflowCount != '1)) begin
        r_underflowCount <= r_underflowCount + ERRCNTBITS'(1);
      end
    end
  end

  assign headHitInfo    = r_mem[r_rdPtr];
  assign headValid      = ~w_empty;
  assign count          = r_count;
  assign full           = (r_count == C_DEPTH);
  assign almost_full    = (r_count >= C_ALMOSTFULL);
  assign dropCount      = r_dropCount;
  assign underflowCount = r_underflowCount;

endmodule
`default_nettype wire

// File: tb/tb_hit_info_queue_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_hit_info_queue_mc
// Purpose  : Self-checking bench for hit_info_queue_mc: queue-based reference
//            model with a scoreboard of expected popped words, plus a small
//            DEPTH=5 instance exercising pointer wrap and underflow.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hit_info_queue_mc;
  import hxmpp_pkg::*;

  localparam int DEPTH  = 16;
  localparam int NLANES = 4;
  localparam int AF     = 12;
  localparam int SATMAX = 65535;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic                  reset       = 1'b1;
  logic                  flush       = 1'b0;
  logic                  pop         = 1'b0;
  logic [NLANES-1:0]     push        = '0;
  logic [NLANES*32-1:0]  pushHitInfo = '0;
  logic [31:0]           headHitInfo;
  logic                  headValid;
  logic [4:0]            count;
  logic                  full;
  logic                  almost_full;
  logic [15:0]           dropCount;
  logic [15:0]           underflowCount;

  hit_info_queue_mc #(
    .HITINFOBITS (32), .DEPTH (DEPTH), .NLANES (NLANES), .ALMOSTFULL (AF), .ERRCNTBITS (16)
  ) dut (
    .clk (clk), .reset (reset), .flush (flush), .push (push), .pushHitInfo (pushHitInfo),
    .pop (pop), .headHitInfo (headHitInfo), .headValid (headValid), .count (count),
    .full (full), .almost_full (almost_full), .dropCount (dropCount),
    .underflowCount (underflowCount)
  );

  // small instance: DEPTH=5, single lane
  logic        reset5 = 1'b1;
  logic        pop5   = 1'b0;
  logic [0:0]  push5  = '0;
  logic [31:0] data5  = '0;
  logic [31:0] head5;
  logic        valid5;
  logic [2:0]  count5;
  logic        full5;
  logic        af5;
  logic [15:0] drop5;
  logic [15:0] uf5;

  hit_info_queue_mc #(
    .HITINFOBITS (32), .DEPTH (5), .NLANES (1), .ALMOSTFULL (4), .ERRCNTBITS (16)
  ) dut5 (
    .clk (clk), .reset (reset5), .flush (1'b0), .push (push5), .pushHitInfo (data5),
    .pop (pop5), .headHitInfo (head5), .headValid (valid5), .count (count5),
    .full (full5), .almost_full (af5), .dropCount (drop5), .underflowCount (uf5)
  );

  int        checks = 0;
  int        errors = 0;
  bit        monOn  = 1'b0;
  hit_info_t mq[$];     // reference queue contents
  hit_info_t expQ[$];   // scoreboard of words that pops should return
  int        mDrop = 0;
  int        mUf   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] pk(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c, input logic [31:0] d);
    return {d, c, b, a};
  endfunction

  // Reference behaviour: pop first (freeing a slot), then lanes in index order while room remains.
  task automatic modelStep();
    if (reset) begin
      mq.delete();
      mDrop = 0;
      mUf   = 0;
    end else begin
      if (flush) mq.delete();
      else if (pop) begin
        if (mq.size() > 0) void'(mq.pop_front());
        else if (mUf < SATMAX) mUf++;
      end
      for (int i = 0; i < NLANES; i++) begin
        if (push[i]) begin
          if (mq.size() < DEPTH) mq.push_back(pushHitInfo[i*32 +: 32]);
          else if (mDrop < SATMAX) mDrop++;
        end
      end
    end
  endtask

  // One cycle: account for the inputs just sampled, then present new ones.
  task automatic drive(input logic [3:0] p, input logic [127:0] d, input logic po,
                       input logic fl, input logic rs);
    @(posedge clk);
    #1;
    modelStep();
    push = p; pushHitInfo = d; pop = po; flush = fl; reset = rs;
    if (!rs && !fl && po && mq.size() > 0) expQ.push_back(mq[0]);
  endtask

  // Monitor: state compared against the model every cycle, head word against the scoreboard on pops.
  initial begin
    hit_info_t e;
    forever begin
      @(negedge clk);
      if (monOn) begin
        check("count", 64'(count), 64'(mq.size()));
        check("headValid", 64'(headValid), 64'(mq.size() != 0));
        check("full", 64'(full), 64'(mq.size() == DEPTH));
        check("almost_full", 64'(almost_full), 64'(mq.size() >= AF));
        check("dropCount", 64'(dropCount), 64'(mDrop));
        check("underflowCount", 64'(underflowCount), 64'(mUf));
        if (pop && !flush && !reset && headValid) begin
          if (expQ.size() == 0) check("pop_unexpected", 64'(headHitInfo), 64'hDEAD_0000_0000);
          else begin
            e = expQ.pop_front();
            check("headHitInfo", 64'(headHitInfo), 64'(e));
          end
        end
      end
    end
  end

  initial begin
    // 1: reset, single push, single pop
    drive(4'b0000, '0, 1'b0, 1'b0, 1'b1);
    monOn = 1'b1;
    drive(4'b0001, pk(32'hA5A5_0001, 0, 0, 0), 1'b0, 1'b0, 1'b0);
    drive(4'b0000, '0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("t1_head", 64'(headHitInfo), 64'hA5A5_0001);
    drive(4'b0000, '0, 1'b0, 1'b0, 1'b0);

    // 2: sparse lane mask keeps ascending order
    drive(4'b1011, pk(32'h10, 32'h11, 32'hEE, 32'h13), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(4'b0000, '0, 1'b1, 1'b0, 1'b0);
    drive(4'b0000, '0, 1'b0, 1'b0, 1'b0);

    // 3: fill to 15, then overflow by three lanes
    for (int i = 0; i < 3; i++)
      drive(4'b1111, pk(32'h100 + 4*i, 32'h101 + 4*i, 32'h102 + 4*i, 32'h103 + 4*i), 1'b0, 1'b0, 1'b0);
    drive(4'b0111, pk(32'h200, 32'h201, 32'h202, 32'h203), 1'b0, 1'b0, 1'b0);
    drive(4'b1111, pk(32'h300, 32'h301, 32'h302, 32'h303), 1'b0, 1'b0, 1'b0);
    // 4: pop and push together while full
    drive(4'b0100, pk(0, 0, 32'h77, 0), 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("t3_dropCount", 64'(dropCount), 64'd3);
    check("t3_full", 64'(full), 64'd1);
    for (int i = 0; i < 16; i++) drive(4'b0000, '0, 1'b1, 1'b0, 1'b0);
    drive(4'b0000, '0, 1'b0, 1'b0, 1'b0);

    // 6a: flush with same-cycle push and pop
    drive(4'b1111, pk(32'h400, 32'h401, 32'h402, 32'h403), 1'b0, 1'b0, 1'b0);
    drive(4'b0111, pk(32'h404, 32'h405, 32'h406, 0), 1'b0, 1'b0, 1'b0);
    drive(4'b0011, pk(32'h21, 32'h22, 0, 0), 1'b1, 1'b1, 1'b0);
    drive(4'b0000, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("t6_count", 64'(count), 64'd2);
    check("t6_head", 64'(headHitInfo), 64'h21);
    check("t6_underflow", 64'(underflowCount), 64'd0);

    // randomized traffic, including occasional flush and reset
    for (int n = 0; n < 600; n++) begin
      logic [3:0]   rp;
      logic [127:0] rd;
      rp = 4'($urandom_range(0, 15));
      rd = {$urandom, $urandom, $urandom, $urandom};
      drive(rp, rd, 1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 2),
            1'($urandom_range(0, 199) < 1));
    end
    drive(4'b0000, '0, 1'b1, 1'b0, 1'b0);
    drive(4'b0000, '0, 1'b1, 1'b0, 1'b0);

    // 6b: reset mid-stream clears everything, push in the same cycle is discarded
    drive(4'b1111, pk(1, 2, 3, 4), 1'b0, 1'b0, 1'b0);
    drive(4'b1111, pk(5, 6, 7, 8), 1'b1, 1'b0, 1'b1);
    drive(4'b0000, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("t6_rst_count", 64'(count), 64'd0);
    check("t6_rst_drop", 64'(dropCount), 64'd0);
    check("t6_rst_underflow", 64'(underflowCount), 64'd0);

    // 5: DEPTH=5 wrap, then two underflows
    @(posedge clk); #1;
    reset5 = 1'b0; push5 = 1'b1; data5 = 32'h5000;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      push5 = 1'b1; data5 = 32'h5000 + 32'(i); pop5 = 1'b1;
      @(negedge clk);
      check("d5_head", 64'(head5), 64'(32'h5000 + 32'(i - 1)));
      check("d5_count", 64'(count5), 64'd1);
    end
    @(posedge clk); #1;
    push5 = 1'b0; pop5 = 1'b1;
    @(negedge clk);
    check("d5_last_head", 64'(head5), 64'h500C);
    @(posedge clk);
    @(negedge clk);
    check("d5_empty_count", 64'(count5), 64'd0);
    check("d5_empty_valid", 64'(valid5), 64'd0);
    @(posedge clk);
    @(posedge clk); #1;
    pop5 = 1'b0;
    @(negedge clk);
    check("d5_underflow", 64'(uf5), 64'd2);
    check("d5_drop", 64'(drop5), 64'd0);
    check("d5_flags", 64'({full5, af5}), 64'd0);

    drive(4'b0000, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("scoreboard_drained", 64'(expQ.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hit_info_queue_mc.md
Name: hit_info_queue_mc

Overview:
Parametrised multi-lane hit-info queue that feeds hit info to HCM in SSID arrival order, one pop per HNM newOutput.
- Circular buffer replaces the single-lane shift-register queue: no per-pop data movement, arbitrary DEPTH.
- Adds NLANES writes per cycle, per-event flush, full/almost-full flags, and saturating drop/underflow counters.

Parameters:
HITINFOBITS, 32, width of one hit-info word
DEPTH, 16, queue entries (any integer >= 2, not restricted to powers of two)
NLANES, 4, parallel write lanes (1..8)
ALMOSTFULL, 12, almost_full asserts when count >= ALMOSTFULL (must satisfy 1 <= ALMOSTFULL <= DEPTH)
ERRCNTBITS, 16, width of drop and underflow counters

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
flush  in  1  end-of-event clear, synchronous
push  in  NLANES  per-lane write strobe
pushHitInfo  in  NLANES*HITINFOBITS  lane i occupies bits [i*HITINFOBITS +: HITINFOBITS]
pop  in  1  consume head entry (driven by HNM newOutput)
headHitInfo  out  HITINFOBITS  entry at read pointer (show-ahead)
headValid  out  1  count != 0
count  out  $clog2(DEPTH+1)  occupancy
full  out  1  count == DEPTH
almost_full  out  1  count >= ALMOSTFULL
dropCount  out  ERRCNTBITS  lanes rejected for lack of space, saturating
underflowCount  out  ERRCNTBITS  pops while empty, saturating

Behaviour:
- Reset (synchronous, active-high, highest priority): rdPtr=0, wrPtr=0, count=0, dropCount=0, underflowCount=0. Hence headValid=0, full=0, almost_full=0 (ALMOSTFULL >= 1). Memory contents are not cleared. Reset asserted mid-operation discards everything on the next edge.
- Show-ahead: headHitInfo = mem[rdPtr] combinationally. The value is don't-care when headValid=0.
- Pop:
  - Effective pop: popEff = pop & (count != 0).
  - pop with count == 0 increments underflowCount and leaves rdPtr unchanged.
- Push capacity:
  - space = DEPTH - count + popEff, so a pop frees its slot in the same cycle.
  - Lanes are served in ascending index order. The k-th asserted lane (k from 0) is accepted iff k < space.
  - Accepted lane k is written to mem[(wrPtr + k) mod DEPTH].
  - Rejected lanes each add 1 to dropCount, saturating at all-ones. Multiple rejections in one cycle add their total, then saturate.
- Pointer and count update:
  - wrPtr += nAccepted (mod DEPTH).
  - rdPtr += popEff (mod DEPTH).
  - count += nAccepted - popEff.
- Wrap: mod DEPTH is implemented by compare-and-subtract. No power-of-two masking.
- Latency: a word pushed into an empty queue appears on headHitInfo with headValid=1 on the cycle after the push edge. Push-to-pop minimum is 1 cycle.
- Flush (reset not asserted):
  - rdPtr=wrPtr=0 and count=0. Any pop in the same cycle is ignored and does not count as underflow.
  - Pushes in the same cycle are accepted against space=DEPTH and written from slot 0, i.e. they become the first entries of the new event.
  - Counters are not cleared by flush.
- Simultaneous push and pop while full: space=1, so exactly one lane is accepted and count stays at DEPTH.
- Flags (full, almost_full, headValid) are derived from the registered count. No combinational path from push/pop to any flag.

Decomposition:
- Shared package hxmpp_pkg: HITINFOBITS, default DEPTH/NLANES, and a hit_info_t typedef of width HITINFOBITS.
- Sub-module lane_compactor: combinational prefix-count over push[] producing per-lane slot offset, accept bit, nAccepted and nRejected.
- Queue top instantiates lane_compactor and holds the memory, pointers and counters.

Test Plan:
1. Reset, then push[0] with 0xA5A5_0001 → next cycle headValid=1, headHitInfo=0xA5A5_0001, count=1. Then pop → count=0, headValid=0.
2. Single cycle with push=4'b1011 carrying data 0x10, 0x11 (lane 1), 0x13 (lane 3) → count=3. Successive pops return 0x10, 0x11, 0x13 in order.
3. Fill to 15, then push=4'b1111 with no pop → 1 accepted (lane 0), count=16, full=1, dropCount=3. almost_full first asserts when count reaches 12.
4. At count=16, pop plus push[2] with value 0x77 → count stays 16. Oldest entry retired; 0x77 appears as the 16th pop.
5. DEPTH=5 build: push and pop 1 per cycle for 12 cycles → data order preserved across 2+ wraps. Then pop on empty twice → underflowCount=2.
6. count=7 with flush, push=4'b0011 (0x21, 0x22) and pop in the same cycle → count=2, head=0x21, underflowCount unchanged. Reset mid-stream → count=0 and both counters return to 0.
